// File: rtl/parking_sensor_gen.sv
// Turns vehicle commands (entry, exit, aborted entry/exit) into the a/b sensor
// waveform seen by the parking FSM, and tracks the expected occupancy count.
module parking_sensor_gen #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   model_count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] T_ENTRY = 2'b00;
  localparam logic [1:0] T_EXIT  = 2'b01;

  state_t             state_q, state_d;
  logic [1:0]         type_q, type_d;
  logic [1:0]         phase_q, phase_d;
  logic [DWELL_W-1:0] left_q, left_d;
  logic [DWELL_W-1:0] dlen_q, dlen_d;
  logic [1:0]         ab_q, ab_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [1:0]         last_phase;

  // {a,b} drive for a given command type and phase index
  function automatic logic [1:0] phase_ab(input logic [1:0] t, input logic [1:0] p);
    logic [1:0] r;
    r = 2'b00;
    case (t)
      2'b00: case (p)
               2'd0: r = 2'b10;
               2'd1: r = 2'b11;
               2'd2: r = 2'b01;
               default: r = 2'b00;
             endcase
      2'b01: case (p)
               2'd0: r = 2'b01;
               2'd1: r = 2'b11;
               2'd2: r = 2'b10;
               default: r = 2'b00;
             endcase
      2'b10: r = (p == 2'd0) ? 2'b10 : 2'b00;
      default: r = (p == 2'd0) ? 2'b01 : 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c,
                                                  input logic [1:0] t);
    logic [CNT_W-1:0] r;
    r = c;
    if (t == T_ENTRY && c != {CNT_W{1'b1}}) r = c + CNT_W'(1);
    if (t == T_EXIT && c != '0)             r = c - CNT_W'(1);
    return r;
  endfunction

  assign dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign last_phase = type_q[1] ? 2'd1 : 2'd3;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    phase_d = phase_q;
    left_d  = left_q;
    dlen_d  = dlen_q;
    ab_d    = ab_q;
    done_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        ab_d = 2'b00;
        if (cmd_valid) begin
          state_d = RUN;
          type_d  = cmd_type;
          dlen_d  = dwell_eff;
          left_d  = dwell_eff - DWELL_W'(1);
          phase_d = 2'd0;
          ab_d    = phase_ab(cmd_type, 2'd0);
        end
      end
      default: begin
        if (left_q != '0) begin
          left_d = left_q - DWELL_W'(1);
        end else if (phase_q == last_phase) begin
          // final (0,0) phase has run its full dwell; count moves with done
          state_d = IDLE;
          done_d  = 1'b1;
          ab_d    = 2'b00;
          count_d = next_count(count_q, type_q);
        end else begin
          phase_d = phase_q + 2'd1;
          left_d  = dlen_q - DWELL_W'(1);
          ab_d    = phase_ab(type_q, phase_q + 2'd1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      type_q  <= 2'b00;
      phase_q <= 2'd0;
      left_q  <= '0;
      dlen_q  <= '0;
      ab_q    <= 2'b00;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      phase_q <= phase_d;
      left_q  <= left_d;
      dlen_q  <= dlen_d;
      ab_q    <= ab_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign cmd_ready   = ~busy;
  assign a           = ab_q[1];
  assign b           = ab_q[0];
  assign done        = done_q;
  assign model_count = count_q;

endmodule
